aud_track_ctrl: RTL and testbench

AUD_TRACK_CTRL -- requirements
Module: aud_track_ctrl

---
 rtl/aud_track_ctrl_pkg.sv | 20 ++
 rtl/aud_track_ctrl_key_edge.sv | 30 +++
 rtl/aud_track_ctrl.sv | 166 ++++++++++++++++
 tb/tb_aud_track_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aud_track_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aud_pkg : shared state encoding and speed-decode limits for aud_track_ctrl  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package aud_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PLAYP = 3'd3,
    ST_RECD  = 3'd4,
    ST_RECDP = 3'd5
  } aud_state_e;

  localparam int unsigned SPEED_MIN = 1;
  localparam int unsigned SPEED_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/aud_track_ctrl_key_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_edge : rising-edge press detector for one debounced button level        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module key_edge (
  input  logic i_AUD_BCLK,
  input  logic i_rst_n,
  input  logic key_i,
  output logic press_o
);

  logic armed_q;
  logic prev_q;

  // armed_q masks the first cycle after reset so a key held through reset is not a press
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= key_i;
    end
  end

  assign press_o = armed_q & key_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/aud_track_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aud_track_ctrl : record/play transport FSM over N_TRACKS equal SRAM regions |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module aud_track_ctrl
  import aud_pkg::*;
#(
  parameter  int ADDR_W   = 20,
  parameter  int N_TRACKS = 4,
  parameter  int SPEED_W  = 4,
  localparam int TRK_W    = $clog2(N_TRACKS)
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [TRK_W-1:0]  i_track_sel,
  input  logic              i_loop,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [2:0]        o_state,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_stop,
  output logic              o_restart,
  output logic [ADDR_W-1:0] o_track_base,
  output logic [ADDR_W-1:0] o_track_end,
  output logic [TRK_W-1:0]  o_cur_track,
  output logic [2:0]        o_speed,
  output logic              o_sram_we_n,
  output logic              o_err
);

  localparam int OFS_W = ADDR_W - TRK_W;

  aud_state_e        state_q, state_d;
  logic [TRK_W-1:0]  cur_d;
  logic [ADDR_W-1:0] len_q [N_TRACKS];
  logic              len_we;
  logic [TRK_W-1:0]  len_idx;
  logic [ADDR_W-1:0] len_val;
  logic              restart_d, err_d;
  logic [ADDR_W-1:0] base_d, end_d;
  logic [2:0]        speed_d;

  logic              w_rec, w_play, w_stop;
  logic [ADDR_W-1:0] w_rec_lim, w_len_max;
  logic              w_play_end;
  int unsigned       w_spd;

  key_edge u_key_rec  (.i_AUD_BCLK(i_AUD_BCLK), .i_rst_n(i_rst_n), .key_i(i_key_rec),  .press_o(w_rec));
  key_edge u_key_play (.i_AUD_BCLK(i_AUD_BCLK), .i_rst_n(i_rst_n), .key_i(i_key_play), .press_o(w_play));
  key_edge u_key_stop (.i_AUD_BCLK(i_AUD_BCLK), .i_rst_n(i_rst_n), .key_i(i_key_stop), .press_o(w_stop));

  assign w_rec_lim  = {o_cur_track, {OFS_W{1'b1}}};
  assign w_len_max  = {{TRK_W{1'b0}}, {OFS_W{1'b1}}};
  // one extra bit so a play address near the top of memory cannot wrap past the end
  assign w_play_end = ({1'b0, i_play_addr} + {{(ADDR_W-2){1'b0}}, o_speed}) >= {1'b0, o_track_end};

  assign w_spd   = 32'(i_speed);
  assign speed_d = (w_spd >= SPEED_MIN && w_spd <= SPEED_MAX) ? 3'(w_spd - 1) : 3'd0;

  always_comb begin
    state_d   = state_q;
    cur_d     = o_cur_track;
    restart_d = 1'b0;
    err_d     = 1'b0;
    len_we    = 1'b0;
    len_idx   = o_cur_track;
    len_val   = i_rec_addr - o_track_base;
    case (state_q)
      ST_IDLE: begin
        if (w_stop) begin
          state_d = ST_IDLE;
        end else if (w_rec) begin
          cur_d   = i_track_sel;
          len_we  = 1'b1;
          len_idx = i_track_sel;
          len_val = '0;
          state_d = ST_RECD;
        end else if (w_play) begin
          cur_d = i_track_sel;
          if (len_q[i_track_sel] != '0) begin
            restart_d = 1'b1;
            state_d   = ST_PLAY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECD: begin
        len_we = 1'b1;
        if (w_stop) begin
          state_d = ST_IDLE;
        end else if (i_rec_addr >= w_rec_lim) begin
          len_val = w_len_max;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (w_rec) begin
          state_d = ST_RECDP;
        end
      end
      ST_RECDP: begin
        if (w_stop)     state_d = ST_IDLE;
        else if (w_rec) state_d = ST_RECD;
      end
      ST_PLAY, ST_PLAYP: begin
        if (w_stop) begin
          state_d = ST_IDLE;
        end else if (w_play_end) begin
          if (i_loop) restart_d = 1'b1;
          else        state_d   = ST_IDLE;
        end else if (w_play) begin
          state_d = (state_q == ST_PLAY) ? ST_PLAYP : ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign base_d = {cur_d, {OFS_W{1'b0}}};
  assign end_d  = base_d + ((len_we && len_idx == cur_d) ? len_val : len_q[cur_d]);

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      o_cur_track  <= '0;
      o_track_base <= '0;
      o_track_end  <= '0;
      o_speed      <= '0;
      o_restart    <= 1'b0;
      o_err        <= 1'b0;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_stop       <= 1'b1;
      o_sram_we_n  <= 1'b1;
      for (int t = 0; t < N_TRACKS; t++) len_q[t] <= '0;
    end else begin
      state_q      <= state_d;
      o_cur_track  <= cur_d;
      o_track_base <= base_d;
      o_track_end  <= end_d;
      o_speed      <= speed_d;
      o_restart    <= restart_d;
      o_err        <= err_d;
      o_rec_start  <= (state_d == ST_RECD);
      o_rec_pause  <= (state_d == ST_RECDP);
      o_play_start <= (state_d == ST_PLAY);
      o_play_pause <= (state_d == ST_PLAYP);
      o_stop       <= (state_d == ST_IDLE);
      o_sram_we_n  <= !(state_d == ST_RECD || state_d == ST_RECDP);
      if (len_we) len_q[len_idx] <= len_val;
    end
  end

  assign o_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_aud_track_ctrl.sv
`default_nettype none
// Scoreboard bench for aud_track_ctrl: stimulus queues expected values, a negedge monitor compares.
module tb_aud_track_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_rec, key_play, key_stop, loop_en;
  logic [1:0]  sel;
  logic [3:0]  speed;
  logic [19:0] rec_addr, play_addr;
  logic [2:0]  st;
  logic        rec_start, rec_pause, play_start, play_pause, stop_o, restart, err, we_n;
  logic [19:0] tbase, tend;
  logic [1:0]  cur;
  logic [2:0]  spd;

  localparam int S_STATE = 0, S_BASE = 1, S_WEN = 2, S_SPD = 3, S_END = 4, S_CUR = 5, S_STOP = 6;

  typedef struct { int cyc; int sig; logic [31:0] val; } chk_t;
  typedef struct { int cyc; bit rs; bit er; } pulse_t;

  chk_t   chk_q[$];
  pulse_t pulse_q[$];
  pulse_t p;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  aud_track_ctrl dut (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n),
    .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
    .i_track_sel(sel), .i_loop(loop_en), .i_speed(speed),
    .i_rec_addr(rec_addr), .i_play_addr(play_addr),
    .o_state(st), .o_rec_start(rec_start), .o_rec_pause(rec_pause),
    .o_play_start(play_start), .o_play_pause(play_pause), .o_stop(stop_o),
    .o_restart(restart), .o_track_base(tbase), .o_track_end(tend),
    .o_cur_track(cur), .o_speed(spd), .o_sram_we_n(we_n), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int s);
    case (s)
      S_STATE: return {29'd0, st};
      S_BASE:  return {12'd0, tbase};
      S_WEN:   return {31'd0, we_n};
      S_SPD:   return {29'd0, spd};
      S_END:   return {12'd0, tend};
      S_CUR:   return {30'd0, cur};
      default: return {31'd0, stop_o};
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      S_STATE: return "o_state";
      S_BASE:  return "o_track_base";
      S_WEN:   return "o_sram_we_n";
      S_SPD:   return "o_speed";
      S_END:   return "o_track_end";
      S_CUR:   return "o_cur_track";
      default: return "o_stop";
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc <= cyc) begin
        n_cmp++;
        if (chk_q[i].cyc != cyc || sample(chk_q[i].sig) !== chk_q[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %0h want %0h (due cyc %0d)",
                   sig_name(chk_q[i].sig), cyc, sample(chk_q[i].sig), chk_q[i].val, chk_q[i].cyc);
        end
        chk_q.delete(i);
      end
    end
    if (restart === 1'b1 || err === 1'b1) begin
      n_cmp++;
      if (pulse_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected pulse @cyc %0d: restart=%b err=%b, none expected", cyc, restart, err);
      end else begin
        p = pulse_q.pop_front();
        if (p.cyc != cyc || p.rs != restart || p.er != err) begin
          n_bad++;
          $display("FAIL pulse @cyc %0d: restart=%b err=%b, want restart=%b err=%b @cyc %0d",
                   cyc, restart, err, p.rs, p.er, p.cyc);
        end
      end
    end
  end

  task automatic expect_at(int d, int s, logic [31:0] v);
    chk_q.push_back('{cyc + d, s, v});
  endtask

  task automatic expect_pulse(int d, bit rs, bit er);
    pulse_q.push_back('{cyc + d, rs, er});
  endtask

  task automatic chk_now(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_vals(string tag);
    chk_now({tag, " o_state"}, {29'd0, st}, 32'd1);
    chk_now({tag, " o_stop"}, {31'd0, stop_o}, 32'd1);
    chk_now({tag, " o_sram_we_n"}, {31'd0, we_n}, 32'd1);
    chk_now({tag, " o_rec_start"}, {31'd0, rec_start}, 32'd0);
    chk_now({tag, " o_restart/o_err"}, {30'd0, restart, err}, 32'd0);
    chk_now({tag, " o_cur_track"}, {30'd0, cur}, 32'd0);
    chk_now({tag, " o_track_base"}, {12'd0, tbase}, 32'd0);
    chk_now({tag, " o_track_end"}, {12'd0, tend}, 32'd0);
    chk_now({tag, " o_speed"}, {29'd0, spd}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; key_rec = 0; key_play = 0; key_stop = 0; loop_en = 0;
    sel = 0; speed = 0; rec_addr = 0; play_addr = 0;
    step(2);
    reset_vals("reset");

    // key held through reset release must not count
    key_rec = 1; rst_n = 1'b1;
    step(3);
    expect_at(0, S_STATE, 1);
    key_rec = 0; step(2);

    // record track 2
    sel = 2; speed = 3; rec_addr = 20'h80000;
    key_rec = 1;
    expect_at(1, S_STATE, 4); expect_at(1, S_BASE, 32'h80000);
    expect_at(1, S_WEN, 0);   expect_at(1, S_CUR, 2); expect_at(1, S_SPD, 2);
    step(1); key_rec = 0;
    for (int a = 1; a <= 16; a++) begin
      rec_addr = 20'h80000 + 20'(a);
      step(1);
    end
    key_stop = 1;
    expect_at(1, S_STATE, 1); expect_at(1, S_WEN, 1); expect_at(1, S_END, 32'h80010);
    step(1); key_stop = 0; step(1);

    // play track 2 to end, no loop
    key_play = 1;
    expect_at(1, S_STATE, 2); expect_pulse(1, 1, 0);
    step(1); key_play = 0; step(2);
    play_addr = 20'h8000E;
    expect_at(1, S_STATE, 1);
    step(1); play_addr = 0; step(1);

    // looped play with pause toggles
    loop_en = 1; key_play = 1;
    expect_at(1, S_STATE, 2); expect_pulse(1, 1, 0);
    step(1); key_play = 0; step(1);
    key_play = 1; expect_at(1, S_STATE, 3); step(1); key_play = 0; step(1);
    key_play = 1; expect_at(1, S_STATE, 2); step(1); key_play = 0; step(1);
    play_addr = 20'h8000E;
    expect_pulse(1, 1, 0); expect_at(1, S_STATE, 2);
    step(1); play_addr = 20'h80000;
    expect_at(1, S_STATE, 2);
    step(1);
    // stop beats loop restart
    key_stop = 1; play_addr = 20'h8000E;
    expect_at(1, S_STATE, 1);
    step(1); key_stop = 0; play_addr = 0; loop_en = 0; step(2);

    // play on empty track 1
    sel = 1; key_play = 1;
    expect_pulse(1, 0, 1); expect_at(1, S_STATE, 1); expect_at(2, S_STATE, 1);
    step(1); key_play = 0; step(2);

    // rec beats play, stop beats rec
    rec_addr = 20'h40005; key_rec = 1; key_play = 1;
    expect_at(1, S_STATE, 4); expect_at(1, S_BASE, 32'h40000); expect_at(1, S_CUR, 1);
    step(1); key_rec = 0; key_play = 0; step(2);
    key_stop = 1; key_rec = 1;
    expect_at(1, S_STATE, 1); expect_at(1, S_WEN, 1);
    step(1); key_stop = 0; key_rec = 0; step(2);

    // held rec toggles once, then overflow on track 2
    sel = 2; rec_addr = 20'h80000; key_rec = 1;
    expect_at(1, S_STATE, 4);
    step(1); key_rec = 0; step(2);
    key_rec = 1;
    expect_at(1, S_STATE, 5); expect_at(2, S_STATE, 5); expect_at(50, S_STATE, 5);
    step(50); key_rec = 0; step(1);
    key_rec = 1; expect_at(1, S_STATE, 4); step(1); key_rec = 0; step(1);
    rec_addr = 20'hBFFFF;
    expect_at(1, S_STATE, 1); expect_pulse(1, 0, 1); expect_at(1, S_END, 32'hBFFFF);
    expect_at(1, S_WEN, 1);
    step(1); rec_addr = 0; step(2);

    // asynchronous reset in the middle of recording track 3
    sel = 3; rec_addr = 20'hC0020; key_rec = 1;
    expect_at(1, S_STATE, 4); expect_at(1, S_BASE, 32'hC0000);
    step(1); key_rec = 0; step(2);
    #1 rst_n = 1'b0;
    #1 reset_vals("async reset");
    step(1); rst_n = 1'b1; step(2);
    key_play = 1;
    expect_pulse(1, 0, 1); expect_at(1, S_STATE, 1);
    step(1); key_play = 0; step(2);

    // speed decode boundaries
    speed = 0; expect_at(1, S_SPD, 0); step(1);
    speed = 8; expect_at(1, S_SPD, 7); step(1);
    speed = 9; expect_at(1, S_SPD, 0); step(1);
    speed = 1; expect_at(1, S_SPD, 0); step(1);
    step(3);

    while (chk_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unchecked %s due cyc %0d want %0h", sig_name(chk_q[0].sig), chk_q[0].cyc, chk_q[0].val);
      void'(chk_q.pop_front());
    end
    while (pulse_q.size() > 0) begin
      p = pulse_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing pulse restart=%b err=%b due cyc %0d", p.rs, p.er, p.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
